data_mem_responder: RTL

Responder end of the core's data-memory port: accepts one load/store request at a time from the datapath's `ALU_result` / `RAM_w_data` / `byte_enable` outputs over a valid/ready handshake. It waits a programmable number of cycles, performs a byte-lane-masked word access on an internal RAM, and returns `RAM_r_data` with a valid/ready response. It sits between the core (or its future load/store stall logic) and on-chip data storage. It lets the core be tested against non-zero memory latency.

---
 rtl/mem_resp_pkg.sv | 19 +
 rtl/ram_be_word.sv | 29 ++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, wait-counter width and the address range check.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  localparam int CNT_W = 4;
  localparam int LANES = 4;

  // A byte address is in range when no bit at or above the word-index field is set.
  function automatic logic word_in_range(input logic [31:0] byte_addr, input int addr_bits);
    return (byte_addr >> addr_bits) == 32'd0;
  endfunction

endpackage

// File: rtl/ram_be_word.sv
// Single-port 32-bit word RAM with per-byte write enables and asynchronous read.
// Contents have no reset; a word is undefined until it has been written.
module ram_be_word
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    w_data,
  input  logic [LANES-1:0]               be,
  output logic [31:0]                    r_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Lane-masked synchronous write; unselected lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && be[i]) begin
        mem[idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  assign r_data = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the core data-memory port: one request at a time, a fixed
// programmable stall, then a byte-masked access to local RAM and a held response.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  input  logic [3:0]  byte_enable,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] r_data,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  resp_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             lat_write_r;
  logic [31:0]      lat_addr_r;
  logic [31:0]      lat_wdata_r;
  logic [3:0]       lat_be_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic [31:0]      r_data_r;
  logic             rsp_err_r;

  logic             in_range_s;
  logic             access_s;
  logic             ram_we_s;
  logic [31:0]      ram_rdata_s;

  // The access happens on the edge that leaves BUSY with an expired counter.
  assign in_range_s = word_in_range(lat_addr_r, AW + 2);
  assign access_s   = (state_r == BUSY) && (cnt_r == {CNT_W{1'b0}});
  assign ram_we_s   = access_s && lat_write_r && in_range_s;

  ram_be_word #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we_s),
    .idx    (lat_addr_r[AW+1:2]),
    .w_data (lat_wdata_r),
    .be     (lat_be_r),
    .r_data (ram_rdata_s)
  );

  // Request/response FSM with wait counter, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      lat_write_r <= 1'b0;
      lat_addr_r  <= 32'd0;
      lat_wdata_r <= 32'd0;
      lat_be_r    <= 4'd0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      r_data_r    <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            lat_write_r <= req_write;
            lat_addr_r  <= addr;
            lat_wdata_r <= w_data;
            lat_be_r    <= byte_enable;
            cnt_r       <= CNT_W'(WAIT_CYCLES);
            req_ready_r <= 1'b0;
            state_r     <= BUSY;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= ~in_range_s;
            r_data_r    <= (!lat_write_r && in_range_s) ? ram_rdata_s : 32'd0;
            state_r     <= RESP;
          end
        end
        RESP: begin
          // Hold the response; a request seen this cycle waits for IDLE.
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            r_data_r    <= 32'd0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= {CNT_W{1'b0}};
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          r_data_r    <= 32'd0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign r_data    = r_data_r;
  assign rsp_err   = rsp_err_r;

endmodule
